// File: rtl/serial_collector_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_collector_if
// Description : Beat-stream and row-write bundle of the serial collector.
//               'master' is the producer/memory side, 'slave' the collector.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_collector_if #(
  parameter int WL        = 16,
  parameter int LANES     = 256,
  parameter int PREC_BITS = 4,
  parameter int AW        = 10
) ();
  localparam int RL = LANES * WL;

  logic                 i_start;
  logic [AW-1:0]        i_base_addr;
  logic [PREC_BITS-1:0] i_prec;
  logic                 i_valid;
  logic                 o_ready;
  logic [LANES-1:0]     i_stream;
  logic                 o_wr_valid;
  logic                 i_wr_ready;
  logic [RL-1:0]        o_wr_data;
  logic [AW-1:0]        o_wr_addr;

  modport master (
    output i_start, i_base_addr, i_prec, i_valid, i_stream, i_wr_ready,
    input  o_ready, o_wr_valid, o_wr_data, o_wr_addr
  );

  modport slave (
    input  i_start, i_base_addr, i_prec, i_valid, i_stream, i_wr_ready,
    output o_ready, o_wr_valid, o_wr_data, o_wr_addr
  );
endinterface
`default_nettype wire

// File: rtl/serial_collector.sv
`default_nettype none
// ============================================================================
// Module      : serial_collector
// Description : Bit-serial to bit-parallel collector. One bit per lane per
//               beat, MSB first, 1..WL beats per row. Words are assembled in
//               two ping-pong row buffers and written out as whole rows with
//               an auto-incrementing row address.
//               Optional build macro SERIAL_COLLECTOR_SIGN_EXT_EN: sign-extend
//               each lane word from bit P-1 at row completion (otherwise the
//               upper bits are zero).
// Revision    : 1.0 - initial release
// ============================================================================
module serial_collector #(
  parameter int WL        = 16,
  parameter int LANES     = 256,
  parameter int PREC_BITS = 4,
  parameter int AW        = 10
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  serial_collector_if.slave bus
);
  localparam int RL = LANES * WL;

  typedef enum logic [1:0] {
    BUF_FREE    = 2'd0,
    BUF_FILLING = 2'd1,
    BUF_FULL    = 2'd2
  } buf_state_t;

  // Buffer bookkeeping (registered and next-state).
  buf_state_t           buf_state     [2];
  buf_state_t           buf_state_nxt [2];
  logic                 fill_ptr;
  logic                 fill_ptr_nxt;
  logic                 drain_ptr;
  logic                 drain_ptr_nxt;
  logic [PREC_BITS-1:0] beat_cnt;
  logic [PREC_BITS-1:0] beat_cnt_nxt;
  logic [PREC_BITS-1:0] prec_q;
  logic [PREC_BITS-1:0] prec_q_nxt;
  logic [AW-1:0]        addr_cnt;
  logic [AW-1:0]        addr_cnt_nxt;

  // Row storage.
  logic [RL-1:0]        row_buf0;
  logic [RL-1:0]        row_buf1;
  logic [RL-1:0]        fill_row_nxt;

  // Beat decode.
  logic                 first_beat;
  logic                 last_beat;
  logic [PREC_BITS-1:0] eff_prec;
  logic                 accept;
  logic                 wr_fire;

  // Handshake outputs come straight from registered buffer state.
  assign bus.o_ready    = (buf_state[fill_ptr] != BUF_FULL);
  assign bus.o_wr_valid = (buf_state[drain_ptr] == BUF_FULL);
  assign bus.o_wr_data  = drain_ptr ? row_buf1 : row_buf0;
  assign bus.o_wr_addr  = addr_cnt;

  // A beat offered in the i_start cycle is dropped even if ready was high.
  assign accept  = bus.i_valid && bus.o_ready && !bus.i_start;
  assign wr_fire = bus.o_wr_valid && bus.i_wr_ready;

  // The precision is only taken from the port on a row's first beat, so the
  // completion test must use the live value on that beat (P=1 rows finish
  // on their first beat).
  assign first_beat = (beat_cnt == '0);
  assign eff_prec   = first_beat ? bus.i_prec : prec_q;
  assign last_beat  = (beat_cnt == eff_prec);

`ifdef SERIAL_COLLECTOR_SIGN_EXT_EN
  // Bits strictly above the sign position P-1 are filled on completion.
  logic [WL-1:0] hi_mask;

  // Decode which word bits lie above the current sign position.
  always_comb begin
    hi_mask = '0;
    for (int b = 0; b < WL; b++) begin
      hi_mask[b] = (b > int'(eff_prec));
    end
  end
`endif

  // Per-lane shift: the first beat of a row starts from an all-zero word so
  // no stale bits survive from the previous row in this buffer.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [WL-2:0] base_low;
    logic [WL-1:0] shifted;

    assign base_low = first_beat ? '0 :
                      (fill_ptr ? row_buf1[k*WL +: WL-1] : row_buf0[k*WL +: WL-1]);
    assign shifted  = {base_low, bus.i_stream[k]};

`ifdef SERIAL_COLLECTOR_SIGN_EXT_EN
    assign fill_row_nxt[k*WL +: WL] = (last_beat && shifted[eff_prec]) ?
                                      (shifted | hi_mask) : shifted;
`else
    assign fill_row_nxt[k*WL +: WL] = shifted;
`endif
  end

  // Next-state logic for buffer states, pointers, beat counter and address.
  always_comb begin
    buf_state_nxt[0] = buf_state[0];
    buf_state_nxt[1] = buf_state[1];
    fill_ptr_nxt     = fill_ptr;
    drain_ptr_nxt    = drain_ptr;
    beat_cnt_nxt     = beat_cnt;
    prec_q_nxt       = prec_q;
    addr_cnt_nxt     = addr_cnt;

    // Drain and fill always target different buffers (the fill buffer is
    // never FULL while accepting), so both may update in one cycle.
    if (wr_fire) begin
      buf_state_nxt[drain_ptr] = BUF_FREE;
      drain_ptr_nxt            = ~drain_ptr;
      addr_cnt_nxt             = addr_cnt + AW'(1);
    end

    if (bus.i_start) begin
      // Restart overrides the increment of a coinciding drain: the next row
      // written goes to the new base.
      addr_cnt_nxt = bus.i_base_addr;
      beat_cnt_nxt = '0;
      for (int b = 0; b < 2; b++) begin
        if (buf_state[b] == BUF_FILLING) begin
          buf_state_nxt[b] = BUF_FREE;
        end
      end
    end else if (accept) begin
      if (first_beat) begin
        prec_q_nxt = bus.i_prec;
      end
      if (last_beat) begin
        buf_state_nxt[fill_ptr] = BUF_FULL;
        fill_ptr_nxt            = ~fill_ptr;
        beat_cnt_nxt            = '0;
      end else begin
        buf_state_nxt[fill_ptr] = BUF_FILLING;
        beat_cnt_nxt            = beat_cnt + PREC_BITS'(1);
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_state[0] <= BUF_FREE;
      buf_state[1] <= BUF_FREE;
      fill_ptr     <= 1'b0;
      drain_ptr    <= 1'b0;
      beat_cnt     <= '0;
      prec_q       <= '0;
      addr_cnt     <= '0;
    end else begin
      buf_state[0] <= buf_state_nxt[0];
      buf_state[1] <= buf_state_nxt[1];
      fill_ptr     <= fill_ptr_nxt;
      drain_ptr    <= drain_ptr_nxt;
      beat_cnt     <= beat_cnt_nxt;
      prec_q       <= prec_q_nxt;
      addr_cnt     <= addr_cnt_nxt;
    end
  end

  // Shift accepted beats into the buffer currently being filled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_buf0 <= '0;
      row_buf1 <= '0;
    end else if (accept) begin
      if (fill_ptr) begin
        row_buf1 <= fill_row_nxt;
      end else begin
        row_buf0 <= fill_row_nxt;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_serial_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_collector
// Description : Self-checking bench for serial_collector. Expected rows are
//               queued when their beats are driven and compared when the
//               collector writes a row out.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_collector;
  localparam int WL        = 16;
  localparam int LANES     = 256;
  localparam int PREC_BITS = 4;
  localparam int AW        = 10;
  localparam int RL        = LANES * WL;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  serial_collector_if #(.WL(WL), .LANES(LANES), .PREC_BITS(PREC_BITS), .AW(AW)) bus ();

  serial_collector #(.WL(WL), .LANES(LANES), .PREC_BITS(PREC_BITS), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [RL-1:0] data;
    logic [AW-1:0] addr;
  } row_t;

  row_t          sb_q [$];
  int            errors    = 0;
  int            checks    = 0;
  int            drains    = 0;
  int            valid_cyc = 0;
  int            cyc       = 0;
  logic [AW-1:0] exp_addr  = '0;
  logic [WL-1:0] vals [LANES];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Reference word: low P bits of the driven value, upper bits zero or sign.
  function automatic logic [WL-1:0] exp_word(input logic [WL-1:0] v, input int p);
    logic [WL-1:0] w;
    w = '0;
    for (int b = 0; b < p; b++) w[b] = v[b];
`ifdef SERIAL_COLLECTOR_SIGN_EXT_EN
    if (v[p-1]) for (int b = p; b < WL; b++) w[b] = 1'b1;
`endif
    return w;
  endfunction

  task automatic rand_vals();
    for (int k = 0; k < LANES; k++) vals[k] = WL'($urandom());
  endtask

  // Drive nbeats beats of a P-bit row from vals; optionally queue the row.
  task automatic send_beats(input int p, input int nbeats, input bit push);
    row_t r;
    if (push) begin
      for (int k = 0; k < LANES; k++) r.data[k*WL +: WL] = exp_word(vals[k], p);
      r.addr   = exp_addr;
      exp_addr = exp_addr + AW'(1);
      sb_q.push_back(r);
    end
    for (int j = 0; j < nbeats; j++) begin
      int t = 0;
      bus.i_prec  = (j == 0) ? PREC_BITS'(p - 1) : PREC_BITS'($urandom_range(0, 15));
      bus.i_valid = 1'b1;
      for (int k = 0; k < LANES; k++) bus.i_stream[k] = vals[k][p-1-j];
      while (!bus.o_ready && t < 200) begin
        @(posedge clk); #1;
        t++;
      end
      if (!bus.o_ready) check("ready timeout", 0, 1);
      @(posedge clk); #1;
    end
  endtask

  task automatic do_start(input logic [AW-1:0] base);
    bus.i_start     = 1'b1;
    bus.i_base_addr = base;
    bus.i_valid     = 1'b1;
    bus.i_stream    = {8{$urandom()}};
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    bus.i_valid = 1'b0;
    exp_addr    = base;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb_q.size() != 0 && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain done", sb_q.size(), 0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Row monitor: every write handshake must match the head of the queue.
  initial forever begin
    row_t r;
    int   bad;
    @(negedge clk);
    if (rst_n && bus.o_wr_valid) valid_cyc++;
    if (rst_n && bus.o_wr_valid && bus.i_wr_ready) begin
      drains++;
      if (sb_q.size() == 0) begin
        check("unexpected row", 1, 0);
      end else begin
        r   = sb_q.pop_front();
        bad = 0;
        for (int k = LANES - 1; k >= 0; k--)
          if (bus.o_wr_data[k*WL +: WL] !== r.data[k*WL +: WL]) bad = k;
        check($sformatf("row@%0d lane%0d", r.addr, bad),
              bus.o_wr_data[bad*WL +: WL], r.data[bad*WL +: WL]);
        check("row addr", bus.o_wr_addr, r.addr);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int v0, d0, c0;
    bus.i_start     = 1'b0;
    bus.i_base_addr = '0;
    bus.i_prec      = '0;
    bus.i_valid     = 1'b0;
    bus.i_stream    = '0;
    bus.i_wr_ready  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst ready", bus.o_ready, 1);
    check("rst wr_valid", bus.o_wr_valid, 0);
    check("rst wr_data nonzero", |bus.o_wr_data, 0);
    check("rst wr_addr", bus.o_wr_addr, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // P=16, lane k carries k, base 5
    bus.i_wr_ready = 1'b1;
    do_start(AW'(5));
    for (int k = 0; k < LANES; k++) vals[k] = WL'(k);
    v0 = valid_cyc;
    send_beats(16, 16, 1);
    bus.i_valid = 1'b0;
    check("latency wr_valid", bus.o_wr_valid, 1);
    repeat (4) @(posedge clk);
    #1;
    check("wr_valid cycles", valid_cyc - v0, 1);
    check("addr after row", bus.o_wr_addr, 6);
    wait_drain();

    // P=4, every lane 4'b1010
    for (int k = 0; k < LANES; k++) vals[k] = 16'h000A;
    send_beats(4, 4, 1);
    bus.i_valid = 1'b0;
    wait_drain();

    // P=2 with the write port blocked: two rows fill, then stall
    bus.i_wr_ready = 1'b0;
    rand_vals();
    send_beats(2, 2, 1);
    rand_vals();
    send_beats(2, 2, 1);
    check("stall ready", bus.o_ready, 0);
    check("stall wr_valid", bus.o_wr_valid, 1);
    d0 = drains;
    rand_vals();
    fork
      send_beats(2, 2, 1);
      begin
        repeat (4) @(posedge clk);
        #1;
        check("still stalled", bus.o_ready, 0);
        check("no drain while blocked", drains - d0, 0);
        bus.i_wr_ready = 1'b1;
        @(posedge clk); #1;
        check("ready after drain", bus.o_ready, 1);
      end
    join
    bus.i_valid = 1'b0;
    wait_drain();

    // P=1 continuous across the address wrap
    do_start(AW'(1020));
    c0 = cyc;
    for (int r = 0; r < 6; r++) begin
      rand_vals();
      send_beats(1, 1, 1);
    end
    bus.i_valid = 1'b0;
    check("p1 cycles for 6 rows", cyc - c0, 6);
    wait_drain();

    // Restart after 7 of 16 beats drops the partial row
    rand_vals();
    send_beats(16, 7, 0);
    do_start(AW'(100));
    rand_vals();
    send_beats(16, 16, 1);
    bus.i_valid = 1'b0;
    wait_drain();

    // Reset with one FULL and one FILLING buffer
    bus.i_wr_ready = 1'b0;
    rand_vals();
    send_beats(4, 4, 0);
    send_beats(4, 2, 0);
    bus.i_valid = 1'b0;
    check("pre-reset wr_valid", bus.o_wr_valid, 1);
    rst_n = 1'b0;
    #1;
    check("async rst wr_valid", bus.o_wr_valid, 0);
    check("async rst ready", bus.o_ready, 1);
    d0 = drains;
    @(posedge clk); #1;
    rst_n          = 1'b1;
    bus.i_wr_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("no row after reset", drains - d0, 0);
    check("queue empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
